// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: gray/binary pointer helpers shared by the write- and read-side FIFO pointer handlers.
// Callers zero-extend into PTR_MAXW bits and truncate the result to their own pointer width.
package fifo_ptr_pkg;
  localparam int PTR_MAXW = 13;
  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational gray-to-binary converter, each bit the XOR of all gray bits at or above it.
module gray_to_bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] g_i,
  output logic [W-1:0] b_o
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b_o[i] = ^g_i[W-1:i];
  end
endmodule

// File: rtl/wptr_handler_lvl.sv
// wptr_handler_lvl: async FIFO write-side pointer handler with level, almost-full threshold and sticky overflow.
// Level and full are computed against the synchronised read pointer, so they lag reads but never under-report.
module wptr_handler_lvl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_RESET   = 2**ADDR_WIDTH-2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   g_rptr_sync,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic                  af_load,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  w_accept,
  output logic [ADDR_WIDTH:0]   b_wptr,
  output logic [ADDR_WIDTH:0]   g_wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);
  localparam int PW = ADDR_WIDTH+1;
  logic [PW-1:0] b_q, b_d, g_q, g_d, lvl_q, lvl_d, thr_q, thr_d, r_bin;
  logic full_q, full_d, af_q, af_d, ovf_q, ovf_d;
  gray_to_bin #(.W(PW)) u_r2b (.g_i(g_rptr_sync), .b_o(r_bin));
  assign w_accept = w_en & ~full_q;
  // Full when the writer is exactly one lap ahead: top two gray bits inverted, the rest equal.
  always_comb begin
    b_d    = b_q + PW'(w_accept);
    g_d    = PW'(bin2gray(PTR_MAXW'(b_d)));
    lvl_d  = b_d - r_bin;
    full_d = g_d == {~g_rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], g_rptr_sync[ADDR_WIDTH-2:0]};
    af_d   = lvl_d >= thr_q;
    ovf_d  = (w_en & full_q) | (ovf_q & ~ovf_clr);
    thr_d  = af_load ? af_thresh : thr_q;
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_q    <= '0;
      g_q    <= '0;
      lvl_q  <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
      thr_q  <= PW'(AF_RESET);
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      lvl_q  <= lvl_d;
      full_q <= full_d;
      af_q   <= af_d;
      ovf_q  <= ovf_d;
      thr_q  <= thr_d;
    end
  end
  assign w_addr      = b_q[ADDR_WIDTH-1:0];
  assign b_wptr      = b_q;
  assign g_wptr      = g_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_level    = lvl_q;
  assign overflow    = ovf_q;
endmodule

// File: doc/wptr_handler_lvl.md
Name: wptr_handler_lvl

Overview:
- Write-domain pointer handler for the parametrised async FIFO. Successor to the fixed 3-bit write pointer handler.
- Adds configurable depth, occupancy level output, programmable almost-full flag, and sticky overflow detection.
- Sits in the wclk domain. It feeds the gray write pointer to the read-side synchroniser and the binary address to the dual-port RAM. It consumes the 2-flop-synchronised gray read pointer.

Parameters:
- ADDR_WIDTH, 3, RAM address bits; depth = 2**ADDR_WIDTH; legal range 2..12.
- AF_RESET, 2**ADDR_WIDTH-2, reset value of the internal almost-full threshold register.

Ports:
- wclk  in  1  write clock
- wrst_n  in  1  async active-low reset
- w_en  in  1  write request
- g_rptr_sync  in  ADDR_WIDTH+1  gray read pointer, already synchronised into wclk
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold in words; sampled when af_load=1
- af_load  in  1  load af_thresh into the threshold register
- ovf_clr  in  1  clear sticky overflow
- w_addr  out  ADDR_WIDTH  RAM write address, equal to b_wptr[ADDR_WIDTH-1:0]
- w_accept  out  1  combinational: w_en & ~full; drives the RAM write enable
- b_wptr  out  ADDR_WIDTH+1  binary write pointer
- g_wptr  out  ADDR_WIDTH+1  gray write pointer; the only signal that crosses clock domains
- full  out  1  FIFO full
- almost_full  out  1  wr_level >= threshold
- wr_level  out  ADDR_WIDTH+1  occupancy as seen from the write side, 0..depth
- overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (wrst_n low, async):
  - b_wptr, g_wptr, wr_level are 0.
  - full, almost_full, overflow are 0.
  - Threshold register is AF_RESET.
- Reset deassertion is synchronous-release by an external synchroniser. Reset mid-operation discards all pointer state immediately. The read side must be reset together.
- Next-state computation, combinational:
  - b_next = b_wptr + w_accept, modulo 2**(ADDR_WIDTH+1).
  - g_next = b_next ^ (b_next >> 1).
  - r_bin = gray-to-binary of g_rptr_sync.
- Registered on posedge wclk; all outputs update on the same edge as the accepted write, so latency is 1 cycle:
  - b_wptr <= b_next; g_wptr <= g_next.
  - full <= (g_next == {~g_rptr_sync[AW:AW-1], g_rptr_sync[AW-2:0]}).
  - wr_level <= b_next - r_bin, modulo 2**(ADDR_WIDTH+1). The result is always <= depth.
  - almost_full <= (b_next - r_bin) >= thr. Unsigned compare. thr=0 forces almost_full=1 after the first edge. thr > depth means almost_full is never asserted.
- Write while full:
  - w_accept=0; pointers hold.
  - overflow <= 1 on that edge.
  - overflow stays set until an ovf_clr edge. If set and clear coincide, set wins.
- af_load: the threshold updates on the edge; the new value is used from the following cycle.
- Simultaneous write and read-pointer advance while full: full deasserts on the edge where g_rptr_sync has advanced. The write attempted in that same cycle is still refused.
- Wrap-around: pointers roll from 2**(AW+1)-1 to 0. The MSB/gray inversion keeps full and wr_level correct across the wrap.
- Pessimism: wr_level and full may lag real reads by the synchroniser delay. They must never under-report occupancy.

Decomposition:
- Package fifo_ptr_pkg holds functions bin2gray(x) and gray2bin(x), parametrised by width via an automatic function with a max-width argument. The read-side handler will share it.
- One sub-module, gray_to_bin, a parametrised combinational XOR-prefix converter, instantiated for r_bin.

Test Plan:
- Fill: AW=3, g_rptr_sync=0, reset then 8 cycles of w_en=1 → after the 8th edge: full=1, b_wptr=4'b1000, g_wptr=4'b1100, wr_level=8. almost_full rises after the 6th edge (AF_RESET=6).
- Overflow: from full, w_en=1 for 2 cycles → b_wptr stays 8, w_accept=0, overflow=1. Pulse ovf_clr with w_en=0 → overflow=0 next edge.
- Drain release: from full, set g_rptr_sync=4'b0001 → next edge full=0, wr_level=7. A w_en in the following cycle is accepted, giving full=1 and b_wptr=9.
- Wrap: reader tracks the writer with 2-cycle lag for 40 writes → b_wptr wraps 15→0. full is never set, wr_level stays ≤ 3, and g_wptr changes exactly 1 bit per accepted write.
- Threshold: af_load with af_thresh=3, then 3 writes → almost_full=1 after the 3rd edge. af_load with af_thresh=9 → almost_full=0 even when full.
- Async reset: assert wrst_n low mid-edge-window while wr_level=5 → all outputs 0 immediately, without waiting for wclk. Threshold returns to 6.
